mult_accumulator: RTL and testbench

Downstream stage of the 4x4 array multiplier in the TinyTapeout tile. Accepts 8-bit unsigned products with a valid/ready handshake and sums them into a saturating accumulator, counting accepted products. On request it snapshots the result and streams it out as three bytes (low, high, status) for the tile's 8-bit output pins.

---
 rtl/mult_accumulator.sv | 135 +++++++++++++
 tb/tb_mult_accumulator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mult_accumulator.sv
// Saturating product accumulator with a snapshot that is read out as three bytes
// (low, high, status) over a valid/ready byte stream.
module mult_accumulator #(
    parameter int ACC_W = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       prod_valid,
    input  logic [7:0] prod,
    output logic       prod_ready,
    input  logic       acc_clear,
    input  logic       dump,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       sat,
    output logic [3:0] count
);

    typedef enum logic [1:0] {ACC, DUMP_LO, DUMP_HI, DUMP_ST} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       count_q, count_d;
    logic             sat_q, sat_d;
    logic [ACC_W-1:0] snap_acc_q, snap_acc_d;
    logic [3:0]       snap_count_q, snap_count_d;
    logic             snap_sat_q, snap_sat_d;

    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_a;
    logic [3:0]       count_a;
    logic             sat_a;
    logic [15:0]      snap16;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ACC;
            acc_q        <= '0;
            count_q      <= '0;
            sat_q        <= 1'b0;
            snap_acc_q   <= '0;
            snap_count_q <= '0;
            snap_sat_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            sat_q        <= sat_d;
            snap_acc_q   <= snap_acc_d;
            snap_count_q <= snap_count_d;
            snap_sat_q   <= snap_sat_d;
        end
    end

    // Accumulator values after applying this cycle's product, if one is offered
    always_comb begin
        sum     = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod};
        acc_a   = acc_q;
        count_a = count_q;
        sat_a   = sat_q;
        if (prod_valid) begin
            acc_a   = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
            count_a = (count_q == 4'hF) ? 4'hF : count_q + 4'd1;
            sat_a   = sat_q | sum[ACC_W];
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        count_d      = count_q;
        sat_d        = sat_q;
        snap_acc_d   = snap_acc_q;
        snap_count_d = snap_count_q;
        snap_sat_d   = snap_sat_q;
        case (state_q)
            ACC: begin
                if (dump) begin
                    snap_acc_d   = acc_a;
                    snap_count_d = count_a;
                    snap_sat_d   = sat_a;
                    state_d      = DUMP_LO;
                    acc_d        = acc_clear ? '0 : acc_a;
                    count_d      = acc_clear ? 4'd0 : count_a;
                    sat_d        = acc_clear ? 1'b0 : sat_a;
                end else if (acc_clear) begin
                    // A product arriving with clear starts the new sum
                    acc_d   = prod_valid ? ACC_W'(prod) : '0;
                    count_d = prod_valid ? 4'd1 : 4'd0;
                    sat_d   = 1'b0;
                end else begin
                    acc_d   = acc_a;
                    count_d = count_a;
                    sat_d   = sat_a;
                end
            end
            default: begin
                if (acc_clear) begin
                    acc_d   = '0;
                    count_d = 4'd0;
                    sat_d   = 1'b0;
                end
                if (out_ready) begin
                    case (state_q)
                        DUMP_LO: state_d = DUMP_HI;
                        DUMP_HI: state_d = DUMP_ST;
                        default: state_d = ACC;
                    endcase
                end
            end
        endcase
    end

    assign snap16 = 16'(snap_acc_q);

    always_comb begin
        prod_ready = (state_q == ACC);
        out_valid  = (state_q != ACC);
        out_last   = (state_q == DUMP_ST);
        case (state_q)
            DUMP_LO: out_byte = snap16[7:0];
            DUMP_HI: out_byte = snap16[15:8];
            DUMP_ST: out_byte = {snap_sat_q, 3'b000, snap_count_q};
            default: out_byte = 8'h00;
        endcase
    end

    assign sat   = sat_q;
    assign count = count_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Table-driven check of mult_accumulator: each row gives the inputs for one cycle
// and the registered outputs expected to be visible during that cycle.
module tb_mult_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prod_valid;
    logic [7:0] prod;
    logic       prod_ready;
    logic       acc_clear;
    logic       dump;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       sat;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;

    mult_accumulator #(.ACC_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_valid (prod_valid),
        .prod       (prod),
        .prod_ready (prod_ready),
        .acc_clear  (acc_clear),
        .dump       (dump),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .sat        (sat),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       pv;
        logic [7:0] p;
        logic       clr;
        logic       dmp;
        logic       ordy;
        logic       e_rdy;
        logic       e_ov;
        logic       e_ol;
        logic [7:0] e_byte;
        logic [3:0] e_cnt;
        logic       e_sat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic pv, input logic [7:0] p,
                       input logic clr, input logic dmp, input logic ordy,
                       input logic e_rdy, input logic e_ov, input logic e_ol,
                       input logic [7:0] e_byte, input int e_cnt, input logic e_sat);
        vec_t v;
        v.rst_n = r; v.pv = pv; v.p = p; v.clr = clr; v.dmp = dmp; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_ol = e_ol; v.e_byte = e_byte;
        v.e_cnt = 4'(e_cnt); v.e_sat = e_sat;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act,
                       input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row %0d: got 0x%02h expected 0x%02h", name, row, act, exp);
        end
    endtask

    function automatic int min15(input int i);
        return (i > 15) ? 15 : i;
    endfunction

    initial begin
        // reset readout: snapshot is zero after reset
        add(1,0,8'h00,0,1,1, 1,0,0,8'h00,0,0);
        add(1,0,8'h00,0,0,1, 0,1,0,8'h00,0,0);
        add(1,0,8'h00,0,0,1, 0,1,0,8'h00,0,0);
        add(1,0,8'h00,0,0,1, 0,1,1,8'h00,0,0);
        // basic sum E1+10+01 = F2
        add(1,1,8'hE1,0,0,0, 1,0,0,8'h00,0,0);
        add(1,1,8'h10,0,0,0, 1,0,0,8'h00,1,0);
        add(1,1,8'h01,0,0,0, 1,0,0,8'h00,2,0);
        add(1,0,8'h00,0,1,1, 1,0,0,8'h00,3,0);
        add(1,0,8'h00,0,0,1, 0,1,0,8'hF2,3,0);
        add(1,0,8'h00,0,0,1, 0,1,0,8'h00,3,0);
        add(1,0,8'h00,0,0,1, 0,1,1,8'h03,3,0);
        add(1,0,8'h00,1,0,0, 1,0,0,8'h00,3,0);
        // backpressure: 18*FF + 46 = 0x1234
        for (int i = 0; i < 18; i++) add(1,1,8'hFF,0,0,0, 1,0,0,8'h00,min15(i),0);
        add(1,1,8'h46,0,0,0, 1,0,0,8'h00,15,0);
        add(1,0,8'h00,0,1,0, 1,0,0,8'h00,15,0);
        for (int i = 0; i < 5; i++) add(1,0,8'h00,0,0,0, 0,1,0,8'h34,15,0);
        add(1,0,8'h00,0,0,1, 0,1,0,8'h34,15,0);
        add(1,0,8'h00,0,0,0, 0,1,0,8'h12,15,0);
        add(1,0,8'h00,0,0,1, 0,1,0,8'h12,15,0);
        add(1,0,8'h00,0,0,1, 0,1,1,8'h0F,15,0);
        // read-and-clear with a product in the same cycle: 0x100 + 5, count 3
        add(1,0,8'h00,1,0,0, 1,0,0,8'h00,15,0);
        add(1,1,8'hFF,0,0,0, 1,0,0,8'h00,0,0);
        add(1,1,8'h01,0,0,0, 1,0,0,8'h00,1,0);
        add(1,1,8'h05,1,1,1, 1,0,0,8'h00,2,0);
        add(1,1,8'h10,0,0,1, 0,1,0,8'h05,0,0);
        add(1,1,8'h10,0,0,1, 0,1,0,8'h01,0,0);
        add(1,1,8'h10,0,0,1, 0,1,1,8'h03,0,0);
        add(1,0,8'h00,0,0,0, 1,0,0,8'h00,0,0);
        // saturation: 257*FF = FFFF exactly, no sat; one more sets sat
        for (int i = 0; i < 257; i++) add(1,1,8'hFF,0,0,0, 1,0,0,8'h00,min15(i),0);
        add(1,0,8'h00,0,1,1, 1,0,0,8'h00,15,0);
        add(1,0,8'h00,0,0,1, 0,1,0,8'hFF,15,0);
        add(1,0,8'h00,0,0,1, 0,1,0,8'hFF,15,0);
        add(1,0,8'h00,0,0,1, 0,1,1,8'h0F,15,0);
        add(1,1,8'hFF,0,0,0, 1,0,0,8'h00,15,0);
        add(1,0,8'h00,0,1,1, 1,0,0,8'h00,15,1);
        add(1,0,8'h00,0,0,1, 0,1,0,8'hFF,15,1);
        add(1,0,8'h00,0,0,1, 0,1,0,8'hFF,15,1);
        add(1,0,8'h00,0,0,1, 0,1,1,8'h8F,15,1);
        // clear-and-load while saturated
        add(1,1,8'h07,1,0,0, 1,0,0,8'h00,15,1);
        add(1,0,8'h00,0,1,1, 1,0,0,8'h00,1,0);
        add(1,0,8'h00,0,0,1, 0,1,0,8'h07,1,0);
        add(1,0,8'h00,0,0,1, 0,1,0,8'h00,1,0);
        add(1,0,8'h00,0,0,1, 0,1,1,8'h01,1,0);
        // reset in the middle of a readout aborts it
        add(1,0,8'h00,0,1,1, 1,0,0,8'h00,1,0);
        add(0,0,8'h00,0,0,1, 0,1,0,8'h07,1,0);
        add(1,0,8'h00,0,0,1, 1,0,0,8'h00,0,0);
        add(1,0,8'h00,0,0,1, 1,0,0,8'h00,0,0);

        // reset edge with a product offered; it must not be counted
        rst_n = 1'b0; prod_valid = 1'b1; prod = 8'hFF;
        acc_clear = 1'b0; dump = 1'b0; out_ready = 1'b0;
        @(posedge clk);

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            chk("prod_ready", r, 8'(prod_ready), 8'(vecs[r].e_rdy));
            chk("out_valid",  r, 8'(out_valid),  8'(vecs[r].e_ov));
            chk("out_last",   r, 8'(out_last),   8'(vecs[r].e_ol));
            chk("out_byte",   r, out_byte,       vecs[r].e_byte);
            chk("count",      r, 8'(count),      8'(vecs[r].e_cnt));
            chk("sat",        r, 8'(sat),        8'(vecs[r].e_sat));
            if (out_valid === 1'b1 && vecs[r].ordy && vecs[r].rst_n)
                $display("byte taken row %0d: 0x%02h last=%0b", r, out_byte, out_last);
            rst_n      = vecs[r].rst_n;
            prod_valid = vecs[r].pv;
            prod       = vecs[r].p;
            acc_clear  = vecs[r].clr;
            dump       = vecs[r].dmp;
            out_ready  = vecs[r].ordy;
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
